// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and the latched request.
// The LSU_SUBWORD_EN macro selects whether byte/half sizes are legal.
package lsu_pkg;

  localparam int LSU_ADDR_MAX_W = 64;

  localparam logic [1:0] LSU_SZ_BYTE = 2'b00;
  localparam logic [1:0] LSU_SZ_HALF = 2'b01;
  localparam logic [1:0] LSU_SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic                      write;
    logic [1:0]                size;
    logic                      is_signed;
    logic [LSU_ADDR_MAX_W-1:0] addr;
    logic [31:0]               wdata;
  } lsu_req_t;

  // Alignment/size legality of a request, evaluated at accept.
  function automatic logic lsu_req_err(input logic [1:0] size, input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
`ifdef LSU_SUBWORD_EN
    case (size)
      LSU_SZ_BYTE: err = 1'b0;
      LSU_SZ_HALF: err = addr_lo[0];
      LSU_SZ_WORD: err = |addr_lo;
      default:     err = 1'b1;
    endcase
`else
    err = (size != LSU_SZ_WORD) || (|addr_lo);
`endif
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
// Without LSU_SUBWORD_EN only full words pass through and the merge logic is absent.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

`ifdef LSU_SUBWORD_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    case (size)
      LSU_SZ_BYTE: load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      LSU_SZ_HALF: load_data = {{16{is_signed & half_lane[15]}}, half_lane};
      default:     load_data = mem_word;
    endcase
  end

  // Each byte lane either takes store data or keeps the word read from memory.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic hit;
    assign hit = ((size == LSU_SZ_BYTE) && (addr_lo == 2'(gi))) ||
                 ((size == LSU_SZ_HALF) && (addr_lo[1] == 1'(gi / 2)));
    assign merge_data[8*gi +: 8] = !hit ? mem_word[8*gi +: 8] :
                                   (size == LSU_SZ_HALF) ? wdata[8*(gi%2) +: 8] : wdata[7:0];
  end
`else
  logic unused_sel;
  assign unused_sel = ^{size, is_signed, addr_lo};
  assign load_data  = mem_word;
  assign merge_data = wdata;
`endif

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit driving a word-wide, 1-cycle-read data memory; sub-word stores are
// done as read-modify-write. Byte/half support is enabled by LSU_SUBWORD_EN.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int LSU_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [LSU_ADDR_W-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [LSU_ADDR_W-1:0] mem_read_addr,
  input  logic [31:0]           mem_read_data,
  output logic                  mem_write_en,
  output logic [LSU_ADDR_W-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data
);

  lsu_state_t            state_reg, state_next;
  lsu_req_t              req_reg;
  logic                  err_reg;
  logic [31:0]           rdata_reg;
  logic [31:0]           wword_reg;
  logic                  accept;
  logic                  req_err;
  logic [31:0]           load_data;
  logic [31:0]           merge_data;
  logic [LSU_ADDR_W-1:0] addr_aligned;
  logic                  unused_addr;

  assign accept       = req_valid && (state_reg == IDLE);
  assign req_err      = lsu_req_err(req_size, req_addr[1:0]);
  assign addr_aligned = {req_reg.addr[LSU_ADDR_W-1:2], 2'b00};
  assign unused_addr  = ^req_reg.addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    mem_write_en   = 1'b0;
    mem_write_addr = '0;
    mem_write_data = '0;
    mem_read_addr  = addr_aligned;
    case (state_reg)
      IDLE: begin
        req_ready     = 1'b1;
        mem_read_addr = '0;
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_write && (req_size == LSU_SZ_WORD)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD:  state_next = CAP;
      CAP: state_next = req_reg.write ? WR : RESP;
      WR: begin
        mem_write_en   = 1'b1;
        mem_write_addr = addr_aligned;
        mem_write_data = wword_reg;
        state_next     = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The store word starts as wdata and is replaced by the merged word for sub-word stores.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_reg   <= '0;
      err_reg   <= 1'b0;
      rdata_reg <= '0;
      wword_reg <= '0;
    end else if (accept) begin
      req_reg.write     <= req_write;
      req_reg.size      <= req_size;
      req_reg.is_signed <= req_signed;
      req_reg.addr      <= LSU_ADDR_MAX_W'(req_addr);
      req_reg.wdata     <= req_wdata;
      err_reg           <= req_err;
      rdata_reg         <= '0;
      wword_reg         <= req_wdata;
    end else if (state_reg == CAP) begin
      if (req_reg.write) begin
        wword_reg <= merge_data;
      end else begin
        rdata_reg <= load_data;
      end
    end
  end

  assign resp_rdata = rdata_reg;

  lsu_lane_align u_align (
    .size       (req_reg.size),
    .is_signed  (req_reg.is_signed),
    .addr_lo    (req_reg.addr[1:0]),
    .mem_word   (mem_read_data),
    .wdata      (req_reg.wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu with a transaction-level memory model and per-cycle compare.
// Expectations adapt to whether LSU_SUBWORD_EN is defined.
`timescale 1ns/1ps
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_read_addr;
  logic [31:0] mem_read_data;
  logic        mem_write_en;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;

  mem_lsu #(.LSU_ADDR_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'h1357_9BDF * (i + 1)) ^ 32'hA5A5_0F0F;
  endfunction

  // Environment memory: 64 words, synchronous read, write at the clock edge.
  logic [31:0] mem [64];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write_en) begin
      mem[mem_write_addr[7:2]] <= mem_write_data;
    end
    mem_read_data <= mem[mem_read_addr[7:2]];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic [31:0] ref_mem [64];
  logic [32:0] exp_resp [int];
  logic [63:0] exp_wr [int];
  int          busy_until = -1;
  logic [31:0] cur_raddr = 32'h0;
  logic        run_cmp = 1'b0;

  logic [31:0] last_rdata;
  logic        last_err;
  int          last_resp_cyc;
  int          resp_count = 0;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          last_wr_cyc;
  int          wr_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [32:0] er;
    logic [63:0] ew;
    if (run_cmp) begin
      check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp.exists(cyc)});
      if (exp_resp.exists(cyc)) begin
        er = exp_resp[cyc];
        check("resp_err", {31'b0, resp_err}, {31'b0, er[32]});
        check("resp_rdata", resp_rdata, er[31:0]);
      end
      check("mem_write_en", {31'b0, mem_write_en}, {31'b0, exp_wr.exists(cyc)});
      if (exp_wr.exists(cyc)) begin
        ew = exp_wr[cyc];
        check("mem_write_addr", mem_write_addr, ew[63:32]);
        check("mem_write_data", mem_write_data, ew[31:0]);
      end
      check("req_ready", {31'b0, req_ready}, {31'b0, (cyc > busy_until)});
      check("mem_read_addr", mem_read_addr, (cyc > busy_until) ? 32'h0 : cur_raddr);
      if (resp_valid) begin
        last_rdata    = resp_rdata;
        last_err      = resp_err;
        last_resp_cyc = cyc;
        resp_count++;
      end
      if (mem_write_en) begin
        last_wr_addr = mem_write_addr;
        last_wr_data = mem_write_data;
        last_wr_cyc  = cyc;
        wr_count++;
      end
    end
  end

  // Reference model: outcome of one request from the size/alignment rules and a word array.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic abort, input int gap, output int n);
    logic        err;
    int          lat;
    int          shift;
    int          idx;
    logic [31:0] word;
    logic [31:0] v;
    logic [31:0] mask;
    logic [31:0] nw;
    repeat (gap) @(negedge clk);
    do begin
      @(negedge clk);
      #1;
    end while (cyc <= busy_until);
`ifdef LSU_SUBWORD_EN
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    err = (sz != 2'd2) || (a[1:0] != 2'b00);
`endif
    idx   = int'(a[7:2]);
    shift = int'(a[1:0]) * 8;
    word  = ref_mem[idx];
    if (err) lat = 1;
    else if (!w) lat = 3;
    else if (sz == 2'd2) lat = 2;
    else lat = 4;
    v = 32'h0;
    if (!err && !w) begin
      v = word >> shift;
      if (sz == 2'd0) begin
        v = v & 32'hFF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        v = v & 32'hFFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
    end
    n = cyc;
    if (!abort) begin
      exp_resp[n + lat] = {err, v};
      if (!err && w) begin
        mask = (sz == 2'd2) ? 32'hFFFF_FFFF : (((sz == 2'd0) ? 32'hFF : 32'hFFFF) << shift);
        nw   = (word & ~mask) | ((wd << shift) & mask);
        exp_wr[n + lat - 1] = {a & 32'hFFFF_FFFC, nw};
        ref_mem[idx] = nw;
      end
    end
    busy_until = n + lat;
    cur_raddr  = a & 32'hFFFF_FFFC;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_size   = 2'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_done();
    while (cyc <= busy_until) @(negedge clk);
    #1;
  endtask

  initial begin
    int n;
    int wc;
    int rc;
    logic [1:0]  sz;
    logic [31:0] a;
    reset_n    = 1'b0;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_write_en", {31'b0, mem_write_en}, 32'h0);
    check("rst_mem_read_addr", mem_read_addr, 32'h0);
    check("rst_mem_write_addr", mem_write_addr, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    mem_init = 1'b0;
    #1;
    reset_n = 1'b1;
    run_cmp = 1'b1;

    // Word store then load.
    wc = wr_count;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 0, n);
    wait_done();
    check("ws_write_count", wr_count - wc, 1);
    check("ws_write_cycle", last_wr_cyc - n, 1);
    check("ws_write_addr", last_wr_addr, 32'h10);
    check("ws_resp_latency", last_resp_cyc - n, 2);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 0, n);
    wait_done();
    check("wl_rdata", last_rdata, 32'hDEAD_BEEF);
    check("wl_resp_latency", last_resp_cyc - n, 3);

    // Signed/unsigned byte load.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01, 1'b0, 0, n);
    wait_done();
    issue(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b0, 0, n);
    wait_done();
`ifdef LSU_SUBWORD_EN
    check("lb_signed", last_rdata, 32'hFFFF_FF80);
    check("lb_latency", last_resp_cyc - n, 3);
    issue(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b0, 0, n);
    wait_done();
    check("lb_unsigned", last_rdata, 32'h0000_0080);
`else
    check("lb_off_err", {31'b0, last_err}, 32'h1);
    check("lb_off_latency", last_resp_cyc - n, 1);
`endif

    // Sub-word read-modify-write.
    issue(1'b1, 2'd2, 1'b0, 32'h30, 32'h1122_3344, 1'b0, 0, n);
    wait_done();
    wc = wr_count;
    issue(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_00AA, 1'b0, 0, n);
    wait_done();
`ifdef LSU_SUBWORD_EN
    check("sb_write_count", wr_count - wc, 1);
    check("sb_write_data", last_wr_data, 32'h1122_AA44);
    check("sb_resp_latency", last_resp_cyc - n, 4);
`else
    check("sb_off_write_count", wr_count - wc, 0);
    check("sb_off_err", {31'b0, last_err}, 32'h1);
`endif
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1'b0, 0, n);
    wait_done();
`ifdef LSU_SUBWORD_EN
    check("sb_readback", last_rdata, 32'h1122_AA44);
`else
    check("sb_off_readback", last_rdata, 32'h1122_3344);
`endif

    // Misaligned half load.
    wc = wr_count;
    issue(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1'b0, 0, n);
    wait_done();
    check("mis_err", {31'b0, last_err}, 32'h1);
    check("mis_rdata", last_rdata, 32'h0);
    check("mis_latency", last_resp_cyc - n, 1);
    check("mis_no_write", wr_count - wc, 0);

    // Reset during CAP.
    wc = wr_count;
    rc = resp_count;
`ifdef LSU_SUBWORD_EN
    issue(1'b1, 2'd0, 1'b0, 32'h51, 32'h77, 1'b1, 0, n);
`else
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b1, 0, n);
`endif
    while (cyc < n + 2) @(negedge clk);
    #1;
    reset_n = 1'b0;
    exp_resp.delete();
    exp_wr.delete();
    busy_until = cyc - 1;
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("rst_mid_no_write", wr_count - wc, 0);
    check("rst_mid_no_resp", resp_count - rc, 0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    issue(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 1'b0, 0, n);
    wait_done();

    // Randomized traffic, half of it forced to aligned words.
    for (int t = 0; t < 400; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? $urandom : {24'h0, 8'($urandom)};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        sz = 2'd2;
        a[1:0] = 2'b00;
      end
      issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b0, $urandom_range(0, 2), n);
    end
    wait_done();
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
